fanout_capture_sequencer: RTL and testbench

Sequences a single shared source register onto a high-fanout broadcast net feeding several hierarchical load groups of flops. Loads are replicated per child instance and reached only through a repeater-buffered tree. Requesting groups are served one at a time in round-robin order. Each served group gets a programmable settle interval, so the buffered net is stable before that group's capture strobe fires. The block sits between the source register (driver side) and the per-group capture enables in the child instances.

---
 rtl/fanout_seq_pkg.sv | 20 ++
 rtl/fanout_capture_sequencer_rr_grant_select.sv | 37 +++
 rtl/fanout_capture_sequencer.sv | 112 +++++++++++
 tb/tb_fanout_capture_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fanout_seq_pkg.sv
// Shared types and constants for the fanout capture sequencer.
// Holds the FSM state enum, default sizes and the index-width helper.
package fanout_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam int DEF_NUM_GROUPS = 2;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_SETTLE_W   = 4;

    function automatic int idx_w(input int n);
        if (n <= 2) return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/fanout_capture_sequencer_rr_grant_select.sv
// Round-robin grant select: first set bit of i_req at or above i_ptr, wrapping.
// Ports: i_req (requests), i_ptr (start index), o_gnt (one-hot), o_idx (index).
module rr_grant_select
    import fanout_seq_pkg::*;
#(
    parameter int N  = DEF_NUM_GROUPS,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx
);

    logic [N-1:0] w_rot;
    logic         w_found;
    int           w_off;
    int           w_sum;

    always_comb begin
        // Rotate so bit 0 is the request at i_ptr.
        w_rot   = N'({i_req, i_req} >> i_ptr);
        w_found = 1'b0;
        w_off   = 0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_off   = k;
            end
        end
        w_sum = int'(i_ptr) + w_off;
        if (w_sum >= N) w_sum = w_sum - N;
        o_idx = w_found ? IW'(w_sum) : '0;
        o_gnt = w_found ? (N'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/fanout_capture_sequencer.sv
// Drives one source word onto a buffered broadcast net, waits a settle
// interval, then strobes the round-robin granted group's capture enable.
// Ports: clk1/rst; src_valid/src_ready/src_data/settle_cycles (source side);
// grp_req/grp_gnt/cap_en (group side); bcast_data (net); busy (status).
module fanout_capture_sequencer
    import fanout_seq_pkg::*;
#(
    parameter int NUM_GROUPS = DEF_NUM_GROUPS,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SETTLE_W   = DEF_SETTLE_W
) (
    input  logic                  clk1,
    input  logic                  rst,
    input  logic                  src_valid,
    output logic                  src_ready,
    input  logic [DATA_W-1:0]     src_data,
    input  logic [SETTLE_W-1:0]   settle_cycles,
    input  logic [NUM_GROUPS-1:0] grp_req,
    output logic [NUM_GROUPS-1:0] grp_gnt,
    output logic [DATA_W-1:0]     bcast_data,
    output logic [NUM_GROUPS-1:0] cap_en,
    output logic                  busy
);

    localparam int IW = idx_w(NUM_GROUPS);
    localparam logic [IW-1:0] LAST = IW'(NUM_GROUPS - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SETTLE_W-1:0]   r_cnt;
    logic [DATA_W-1:0]     r_data;
    logic [NUM_GROUPS-1:0] r_gnt;
    logic [IW-1:0]         r_idx;
    logic [IW-1:0]         r_ptr;
    logic [NUM_GROUPS-1:0] w_gnt;
    logic [IW-1:0]         w_idx;
    logic                  w_accept;

    rr_grant_select #(
        .N  (NUM_GROUPS),
        .IW (IW)
    ) u_sel (
        .i_req (grp_req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    // Gated by rst so nothing is offered or strobed during a reset cycle.
    assign src_ready  = (r_state == IDLE) && (|grp_req) && !rst;
    assign w_accept   = src_valid && src_ready;
    assign grp_gnt    = r_gnt;
    assign bcast_data = r_data;

    always_ff @(posedge clk1) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        cap_en      = '0;
        busy        = (r_state != IDLE);
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (settle_cycles != '0) ? SETTLE : CAPTURE;
                end
            end
            SETTLE: begin
                if (r_cnt <= SETTLE_W'(1)) w_state_nxt = CAPTURE;
            end
            CAPTURE: begin
                cap_en      = rst ? '0 : r_gnt;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_cnt  <= '0;
            r_data <= '0;
            r_gnt  <= '0;
            r_idx  <= '0;
            r_ptr  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_data <= src_data;
                        r_cnt  <= settle_cycles;
                        r_gnt  <= w_gnt;
                        r_idx  <= w_idx;
                    end
                end
                SETTLE: begin
                    r_cnt <= r_cnt - SETTLE_W'(1);
                end
                CAPTURE: begin
                    r_ptr <= (r_idx == LAST) ? '0 : r_idx + IW'(1);
                    r_gnt <= '0;
                end
                default: begin
                    r_gnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fanout_capture_sequencer.sv
// Directed bench for fanout_capture_sequencer with a capture scoreboard.
// Expected capture events are queued at accept and matched on cap_en.
module tb_fanout_capture_sequencer;

    logic       clk1;
    logic       rst;
    logic       src_valid;
    logic       src_ready;
    logic [7:0] src_data;
    logic [3:0] settle_cycles;
    logic [1:0] grp_req;
    logic [1:0] grp_gnt;
    logic [7:0] bcast_data;
    logic [1:0] cap_en;
    logic       busy;

    fanout_capture_sequencer #(
        .NUM_GROUPS (2),
        .DATA_W     (8),
        .SETTLE_W   (4)
    ) dut (
        .clk1          (clk1),
        .rst           (rst),
        .src_valid     (src_valid),
        .src_ready     (src_ready),
        .src_data      (src_data),
        .settle_cycles (settle_cycles),
        .grp_req       (grp_req),
        .grp_gnt       (grp_gnt),
        .bcast_data    (bcast_data),
        .cap_en        (cap_en),
        .busy          (busy)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    typedef struct {
        int         cyc;
        logic [1:0] gnt;
        logic [7:0] data;
    } exp_t;

    exp_t       q[$];
    int         cyc;
    int         vectors;
    int         miscompares;
    int         m_ptr;
    logic [7:0] m_data;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk1);
        #1;
        cyc++;
        if (cap_en !== 2'b00) begin
            if (q.size() == 0) begin
                chk("cap_unexpected", 32'(cap_en), 32'd0);
            end else begin
                e = q.pop_front();
                chk("cap_gnt", 32'(cap_en), 32'(e.gnt));
                chk("cap_cycle", cyc, e.cyc);
                chk("cap_data", 32'(bcast_data), 32'(e.data));
            end
        end
    endtask

    function automatic logic [1:0] pick(input logic [1:0] req, input int ptr);
        int j;
        for (int i = 0; i < 2; i++) begin
            j = (ptr + i) % 2;
            if (req[j[0]]) return 2'(1) << j;
        end
        return 2'b00;
    endfunction

    function automatic int gidx(input logic [1:0] g);
        return g[1] ? 1 : 0;
    endfunction

    task automatic push(input int c, input logic [1:0] g, input logic [7:0] d);
        exp_t e;
        e.cyc  = c;
        e.gnt  = g;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic xfer(input logic [7:0] d, input logic [3:0] s,
                        input logic [1:0] req);
        logic [1:0] g;
        g = pick(req, m_ptr);
        src_valid     = 1'b1;
        src_data      = d;
        settle_cycles = s;
        grp_req       = req;
        #1;
        chk("xfer_ready", 32'(src_ready), 32'd1);
        push(cyc + 1 + int'(s), g, d);
        step();
        src_valid = 1'b0;
        chk("xfer_busy", 32'(busy), 32'd1);
        chk("xfer_gnt", 32'(grp_gnt), 32'(g));
        chk("xfer_bcast", 32'(bcast_data), 32'(d));
        for (int i = 0; i < int'(s) + 1; i++) step();
        chk("xfer_idle", 32'(busy), 32'd0);
        chk("xfer_gnt_clr", 32'(grp_gnt), 32'd0);
        m_ptr  = (gidx(g) + 1) % 2;
        m_data = d;
    endtask

    initial begin
        logic [1:0] g;
        cyc           = 0;
        vectors       = 0;
        miscompares   = 0;
        m_ptr         = 0;
        m_data        = 8'h00;
        rst           = 1'b1;
        src_valid     = 1'b0;
        src_data      = 8'h00;
        settle_cycles = 4'd0;
        grp_req       = 2'b00;

        repeat (3) step();
        chk("rst_ready", 32'(src_ready), 32'd0);
        chk("rst_gnt", 32'(grp_gnt), 32'd0);
        chk("rst_cap", 32'(cap_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bcast", 32'(bcast_data), 32'd0);
        rst = 1'b0;
        step();

        // S=0: capture in the first cycle after accept.
        xfer(8'hA5, 4'd0, 2'b01);

        // Reset mid-SETTLE with ptr=1 before the reset.
        g = pick(2'b11, m_ptr);
        src_valid     = 1'b1;
        src_data      = 8'h5A;
        settle_cycles = 4'd7;
        grp_req       = 2'b11;
        #1;
        chk("mid_ready", 32'(src_ready), 32'd1);
        step();
        src_valid = 1'b0;
        chk("mid_gnt", 32'(grp_gnt), 32'(g));
        step();
        step();
        rst     = 1'b1;
        grp_req = 2'b00;
        step();
        chk("mid_rst_gnt", 32'(grp_gnt), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_bcast", 32'(bcast_data), 32'd0);
        chk("mid_rst_cap", 32'(cap_en), 32'd0);
        chk("mid_rst_ready", 32'(src_ready), 32'd0);
        rst    = 1'b0;
        m_ptr  = 0;
        m_data = 8'h00;
        repeat (10) step();

        // Round-robin starting from a cleared pointer: 01,10,01,10.
        xfer(8'h11, 4'd3, 2'b11);
        chk("rr_ptr0", m_ptr, 1);
        xfer(8'h22, 4'd3, 2'b11);
        xfer(8'h33, 4'd3, 2'b11);
        xfer(8'h44, 4'd3, 2'b11);

        // Request dropped mid-transaction.
        g = pick(2'b10, m_ptr);
        src_valid     = 1'b1;
        src_data      = 8'h77;
        settle_cycles = 4'd5;
        grp_req       = 2'b10;
        #1;
        chk("drop_ready", 32'(src_ready), 32'd1);
        push(cyc + 6, g, 8'h77);
        step();
        src_valid = 1'b0;
        step();
        grp_req = 2'b00;
        repeat (5) step();
        chk("drop_idle", 32'(busy), 32'd0);
        m_ptr  = (gidx(g) + 1) % 2;
        m_data = 8'h77;

        // src_valid held through a busy transaction.
        g = pick(2'b01, m_ptr);
        src_valid     = 1'b1;
        src_data      = 8'h3C;
        settle_cycles = 4'd4;
        grp_req       = 2'b01;
        #1;
        chk("blk_ready", 32'(src_ready), 32'd1);
        push(cyc + 5, g, 8'h3C);
        step();
        src_data = 8'hC3;
        for (int i = 0; i < 5; i++) begin
            chk("blk_ready_busy", 32'(src_ready), 32'd0);
            chk("blk_bcast_hold", 32'(bcast_data), 32'h3C);
            step();
        end
        chk("blk_ready_idle", 32'(src_ready), 32'd1);
        chk("blk_bcast_idle", 32'(bcast_data), 32'h3C);
        m_ptr = (gidx(g) + 1) % 2;
        g = pick(2'b01, m_ptr);
        push(cyc + 5, g, 8'hC3);
        step();
        src_valid = 1'b0;
        chk("blk_bcast_new", 32'(bcast_data), 32'hC3);
        repeat (5) step();
        chk("blk_idle", 32'(busy), 32'd0);
        m_ptr  = (gidx(g) + 1) % 2;
        m_data = 8'hC3;

        // No requesters: nothing accepted.
        src_valid = 1'b1;
        src_data  = 8'hEE;
        grp_req   = 2'b00;
        #1;
        chk("noreq_ready", 32'(src_ready), 32'd0);
        step();
        src_valid = 1'b0;
        chk("noreq_busy", 32'(busy), 32'd0);
        chk("noreq_gnt", 32'(grp_gnt), 32'd0);
        chk("noreq_bcast", 32'(bcast_data), 32'(m_data));

        // Maximum settle interval.
        xfer(8'h96, 4'd15, 2'b11);

        repeat (3) step();
        chk("sb_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
